// File: rtl/tribus_scanner.sv
// Scanner for tri-state sources on one shared bus: enables one source at a time with a
// break-before-make gap, samples the bus and hands each word out over valid/ready.
// Optional macro CHANGE_ONLY_EN: suppress words equal to the last value seen from that source.
module tribus_scanner #(
  parameter int W      = 4,
  parameter int NSRC   = 4,
  parameter int SETTLE = 1
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            START,
  input  logic [NSRC-1:0] MASK,
  input  logic [W-1:0]    BUS,
  output logic [NSRC-1:0] OE,
  output logic [W-1:0]    DOUT,
  output logic [2:0]      DSRC,
  output logic            DVALID,
  input  logic            DREADY,
  output logic            BUSY,
  output logic            DONE,
  output logic [1:0]      DBG_STATE
);

  // Handshake: a word transfers on a rising edge where DVALID && DREADY; DOUT, DSRC and
  // DVALID stay frozen while DVALID=1 and DREADY=0.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GAP   = 2'd1,
    S_DRIVE = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [W-1:0]    dout_q, dout_d;
  logic [2:0]      dsrc_q, dsrc_d;
  logic            dvalid_q, dvalid_d;
  logic            done_q, done_d;

  logic [NSRC-1:0] sel_oh;
  logic [NSRC-1:0] rem_mask;
  logic            last_cyc;
  logic            drop;

  function automatic logic [2:0] lowest(input logic [NSRC-1:0] m);
    lowest = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (m[i]) lowest = 3'(i);
    end
  endfunction

  assign sel_oh   = {{(NSRC-1){1'b0}}, 1'b1} << sel_q;
  assign rem_mask = mask_q & ~sel_oh;
  assign last_cyc = (cnt_q == 3'(SETTLE));

`ifdef CHANGE_ONLY_EN
  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [W-1:0]    hist_q [NSRC];
  logic [NSRC-1:0] seen_q;
  logic [SW-1:0]   sel_idx;

  assign sel_idx = sel_q[SW-1:0];
  assign drop    = seen_q[sel_idx] && (hist_q[sel_idx] == BUS);

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      seen_q <= '0;
      for (int i = 0; i < NSRC; i++) hist_q[i] <= '0;
    end else if (state_q == S_DRIVE && last_cyc && !drop) begin
      hist_q[sel_idx] <= BUS;
      seen_q[sel_idx] <= 1'b1;
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dsrc_d   = dsrc_q;
    dvalid_d = dvalid_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (|MASK) begin
            mask_d  = MASK;
            sel_d   = lowest(MASK);
            state_d = S_GAP;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_GAP: begin
        cnt_d   = 3'd0;
        state_d = S_DRIVE;
      end
      S_DRIVE: begin
        if (!last_cyc) begin
          cnt_d = cnt_q + 3'd1;
        end else if (!drop) begin
          dout_d   = BUS;
          dsrc_d   = sel_q;
          dvalid_d = 1'b1;
          state_d  = S_HOLD;
        end else begin
          // Suppressed word: retire this source exactly as an accepted one would be.
          mask_d = rem_mask;
          if (|rem_mask) begin
            sel_d   = lowest(rem_mask);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (DREADY) begin
          dvalid_d = 1'b0;
          mask_d   = rem_mask;
          if (|rem_mask) begin
            sel_d   = lowest(rem_mask);
            state_d = S_GAP;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state_q  <= S_IDLE;
      mask_q   <= '0;
      sel_q    <= 3'd0;
      cnt_q    <= 3'd0;
      dout_q   <= '0;
      dsrc_q   <= 3'd0;
      dvalid_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dsrc_q   <= dsrc_d;
      dvalid_q <= dvalid_d;
      done_q   <= done_d;
    end
  end

  // OE decodes from registered state only, so reset releases the bus without a clock.
  always_comb begin
    OE = '1;
    if (state_q == S_DRIVE) OE = ~sel_oh;
  end

  assign DOUT      = dout_q;
  assign DSRC      = dsrc_q;
  assign DVALID    = dvalid_q;
  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_tribus_scanner.sv
// Directed bench for tribus_scanner: bus source model, handshake monitor and scoreboard.
module tb_tribus_scanner;
  localparam int W    = 4;
  localparam int NSRC = 4;

  logic            CLK = 1'b0;
  logic            CLR = 1'b0;
  logic            START = 1'b0;
  logic            DREADY = 1'b0;
  logic [NSRC-1:0] MASK = '0;
  logic [NSRC-1:0] OE;
  logic [W-1:0]    BUS;
  logic [W-1:0]    DOUT;
  logic [2:0]      DSRC;
  logic            DVALID;
  logic            BUSY;
  logic            DONE;
  logic [1:0]      DBG_STATE;

  logic [W-1:0] src_val [NSRC];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0;
  int oe_viol = 0;
  int oe_low_seen = 0;
  logic [NSRC-1:0] prev_oe = '1;

  logic [6:0] exp_q[$];
  logic [6:0] got_q[$];
  int         got_cyc_q[$];

  tribus_scanner #(.W(W), .NSRC(NSRC), .SETTLE(1)) dut (
    .CLK(CLK), .CLR(CLR), .START(START), .MASK(MASK), .BUS(BUS),
    .OE(OE), .DOUT(DOUT), .DSRC(DSRC), .DVALID(DVALID), .DREADY(DREADY),
    .BUSY(BUSY), .DONE(DONE), .DBG_STATE(DBG_STATE)
  );

  // clock / reset
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // tri-state sources: whichever source has OE=0 drives the bus
  always_comb begin
    BUS = '0;
    for (int i = 0; i < NSRC; i++) if (!OE[i]) BUS = src_val[i];
  end

  // monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (DVALID && DREADY) begin
      got_q.push_back({DSRC, DOUT});
      got_cyc_q.push_back(cyc);
    end
    if (DONE) done_cnt++;
    if (OE != '1) oe_low_seen++;
    if ($countones(~OE) > 1) oe_viol++;
    if (OE != '1 && prev_oe != '1 && OE != prev_oe) oe_viol++;
    prev_oe = OE;
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b0;
    START = 1'b0;
    DREADY = 1'b0;
    MASK = '0;
    repeat (2) tick();
    CLR = 1'b1;
    tick();
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    oe_viol = 0;
    oe_low_seen = 0;
  endtask

  task automatic set_sources(input logic [W-1:0] a, b, c, d);
    src_val[0] = a; src_val[1] = b; src_val[2] = c; src_val[3] = d;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (done_cnt == d0) begin
      errors++;
      $display("FAIL %s_timeout: DONE not seen after %0d cycles, required within 200", name, n);
    end
  endtask

  task automatic run_scan(input logic [NSRC-1:0] m, input string name);
    int d0;
    got_q.delete();
    got_cyc_q.delete();
    d0 = done_cnt;
    MASK = m;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(d0, name);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    int n;
    CLR = 1'b0;
    repeat (2) tick();
    checks++;
    if ({OE, DVALID, BUSY, DONE} !== {4'b1111, 3'b000}) begin
      errors++;
      $display("FAIL reset_ctrl: OE=%b DVALID=%b BUSY=%b DONE=%b, required 1111 0 0 0", OE, DVALID, BUSY, DONE);
    end
    checks++;
    if ({DOUT, DSRC} !== 7'd0) begin
      errors++;
      $display("FAIL reset_data: DOUT=%h DSRC=%0d, required 0 0", DOUT, DSRC);
    end
    CLR = 1'b1;
    tick();
    set_sources(4'h5, 4'hC, 4'h3, 4'hA);
    DREADY = 1'b1;
    MASK = 4'b1111;
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (OE == 4'b1111 && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (OE !== 4'b1110) begin
      errors++;
      $display("FAIL reset_drive_entry: OE=%b, required 1110 before mid-scan reset", OE);
    end
    #3;
    CLR = 1'b0;
    #1;
    checks++;
    if ({OE, DVALID, BUSY} !== {4'b1111, 2'b00}) begin
      errors++;
      $display("FAIL reset_async: OE=%b DVALID=%b BUSY=%b, required 1111 0 0 before any edge", OE, DVALID, BUSY);
    end
    tick();
    CLR = 1'b1;
    DREADY = 1'b0;
    tick();
  endtask

  task automatic test_full_scan();
    int start_cyc;
    int d0;
    logic [6:0] e;
    do_reset();
    set_sources(4'h5, 4'hC, 4'h3, 4'hA);
    exp_q.push_back({3'd0, 4'h5});
    exp_q.push_back({3'd1, 4'hC});
    exp_q.push_back({3'd2, 4'h3});
    exp_q.push_back({3'd3, 4'hA});
    DREADY = 1'b1;
    d0 = done_cnt;
    MASK = 4'b1111;
    START = 1'b1;
    start_cyc = cyc;
    tick();
    START = 1'b0;
    MASK = 4'b0001;
    wait_done(d0, "full");
    repeat (5) tick();
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL full_done: %0d DONE pulses, required 1", done_cnt - d0);
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL full_count: %0d words, required 4", got_q.size());
    end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL full_word%0d: DSRC=%0d DOUT=%h, required DSRC=%0d DOUT=%h", i, got_q[i][6:4], got_q[i][3:0], e[6:4], e[3:0]);
      end
    end
    if (got_cyc_q.size() == 4) begin
      checks++;
      if (got_cyc_q[0] != start_cyc + 4) begin
        errors++;
        $display("FAIL full_latency: first DVALID at cycle %0d, required %0d", got_cyc_q[0], start_cyc + 4);
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (got_cyc_q[i] - got_cyc_q[i-1] != 4) begin
          errors++;
          $display("FAIL full_spacing%0d: gap %0d cycles, required 4", i, got_cyc_q[i] - got_cyc_q[i-1]);
        end
      end
    end
    checks++;
    if (oe_viol != 0) begin
      errors++;
      $display("FAIL full_oe_invariant: %0d violations, required 0", oe_viol);
    end
  endtask

  task automatic test_sparse_backpressure();
    int n;
    int d0;
    do_reset();
    set_sources(4'h5, 4'hC, 4'h3, 4'hA);
    DREADY = 1'b0;
    d0 = done_cnt;
    MASK = 4'b1010;
    START = 1'b1;
    tick();
    START = 1'b0;
    n = 0;
    while (!DVALID && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({DVALID, DSRC, DOUT, OE} !== {1'b1, 3'd1, 4'hC, 4'b1111}) begin
        errors++;
        $display("FAIL sparse_hold%0d: DVALID=%b DSRC=%0d DOUT=%h OE=%b, required 1 1 c 1111", i, DVALID, DSRC, DOUT, OE);
      end
      tick();
    end
    DREADY = 1'b1;
    wait_done(d0, "sparse");
    repeat (3) tick();
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL sparse_count: %0d words, required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {3'd1, 4'hC} || got_q[1] !== {3'd3, 4'hA}) begin
        errors++;
        $display("FAIL sparse_words: %h %h, required 1c 3a", got_q[0], got_q[1]);
      end
    end
    checks++;
    if (oe_viol != 0) begin
      errors++;
      $display("FAIL sparse_oe_invariant: %0d violations, required 0", oe_viol);
    end
  endtask

  task automatic test_mask_zero();
    int d0;
    do_reset();
    d0 = done_cnt;
    MASK = 4'b0000;
    START = 1'b1;
    tick();
    START = 1'b0;
    checks++;
    if ({DONE, BUSY} !== 2'b10) begin
      errors++;
      $display("FAIL zero_done: DONE=%b BUSY=%b, required 1 0", DONE, BUSY);
    end
    tick();
    checks++;
    if (DONE !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_width: DONE=%b on second cycle, required 0", DONE);
    end
    repeat (3) tick();
    checks++;
    if (oe_low_seen != 0 || got_q.size() != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL zero_quiet: OE-low cycles=%0d words=%0d dones=%0d, required 0 0 1", oe_low_seen, got_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    do_reset();
    set_sources(4'h5, 4'hC, 4'h3, 4'hA);
    DREADY = 1'b1;
    d0 = done_cnt;
    MASK = 4'b0011;
    START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL restart_busy: BUSY=%b, required 1", BUSY);
    end
    MASK = 4'b1111;
    START = 1'b1;
    tick();
    START = 1'b0;
    wait_done(d0, "restart");
    repeat (10) tick();
    checks++;
    if (got_q.size() != 2 || done_cnt - d0 != 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL restart_ignored: words=%0d dones=%0d BUSY=%b, required 2 1 0", got_q.size(), done_cnt - d0, BUSY);
    end
  endtask

`ifdef CHANGE_ONLY_EN
  task automatic test_change_only();
    int d0;
    do_reset();
    set_sources(4'h5, 4'hC, 4'h3, 4'hA);
    DREADY = 1'b1;
    run_scan(4'b1111, "chg1");
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("FAIL chg_scan1: %0d words, required 4", got_q.size());
    end
    d0 = done_cnt;
    run_scan(4'b1111, "chg2");
    checks++;
    if (got_q.size() != 0 || done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL chg_scan2: words=%0d dones=%0d, required 0 1", got_q.size(), done_cnt - d0);
    end
    src_val[2] = 4'h8;
    run_scan(4'b1111, "chg3");
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL chg_scan3_count: %0d words, required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== {3'd2, 4'h8}) begin
        errors++;
        $display("FAIL chg_scan3_word: DSRC=%0d DOUT=%h, required 2 8", got_q[0][6:4], got_q[0][3:0]);
      end
    end
  endtask
`endif

  initial begin
    set_sources(4'h0, 4'h0, 4'h0, 4'h0);
    test_reset();
    test_full_scan();
    test_sparse_backpressure();
    test_mask_zero();
    test_back_to_back();
`ifdef CHANGE_ONLY_EN
    test_change_only();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
